// File: rtl/kamikaze_decode.sv
// kamikaze_decode: RV32I ID stage with register file, load-use interlock and registered ID/EX bundle.
// Optional KAMIKAZE_DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the operand reads.
module kamikaze_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] REG_INIT = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        is_compressed_instr_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [2:0]  op_class_o,
    output logic [2:0]  funct3_o,
    output logic        funct7b5_o,
    output logic        auipc_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] CL_OP     = 3'd0;
    localparam logic [2:0] CL_OPIMM  = 3'd1;
    localparam logic [2:0] CL_LOAD   = 3'd2;
    localparam logic [2:0] CL_STORE  = 3'd3;
    localparam logic [2:0] CL_BRANCH = 3'd4;
    localparam logic [2:0] CL_JAL    = 3'd5;
    localparam logic [2:0] CL_JALR   = 3'd6;
    localparam logic [2:0] CL_UPPER  = 3'd7;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        auipc;
        logic        funct7b5;
        logic [2:0]  funct3;
        logic [2:0]  op_class;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } idex_t;

    localparam idex_t IDEX_RST = '{
        valid: 1'b0, illegal: 1'b0, auipc: 1'b0, funct7b5: 1'b0,
        funct3: 3'd0, op_class: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
        pc: RESET_PC, pc_next: RESET_PC + 32'd4, imm: 32'd0,
        rs1_data: 32'd0, rs2_data: 32'd0
    };

    idex_t       idex_q, idex_d;
    logic [31:0] rf_q [32];

    logic [6:0]  opc;
    logic [2:0]  dec_class;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic        dec_ill, use_rs1, use_rs2;
    logic [4:0]  ra1, ra2;
    logic [31:0] rdata1, rdata2;
    logic        load_use, ready, accept;

    assign opc = instr_i[6:0];

    always_comb begin
        dec_class = CL_OP;
        dec_imm   = 32'd0;
        dec_rd    = instr_i[11:7];
        dec_ill   = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        unique case (opc)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                dec_class = (opc == OPC_OPIMM) ? CL_OPIMM :
                            (opc == OPC_LOAD)  ? CL_LOAD  : CL_JALR;
                dec_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
                use_rs1   = 1'b1;
            end
            OPC_STORE: begin
                dec_class = CL_STORE;
                dec_imm   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_class = CL_BRANCH;
                dec_imm   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_JAL: begin
                dec_class = CL_JAL;
                dec_imm   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_class = CL_UPPER;
                dec_imm   = {instr_i[31:12], 12'b0};
            end
            // FENCE retires as a side-effect-free OP-IMM nop
            OPC_FENCE: begin
                dec_class = CL_OPIMM;
                dec_rd    = 5'd0;
            end
            default: begin
                dec_ill = 1'b1;
                dec_rd  = 5'd0;
            end
        endcase
    end

    assign load_use = idex_q.valid && (idex_q.op_class == CL_LOAD)
                   && (idex_q.rd != 5'd0) && instr_valid_i
                   && ((use_rs1 && instr_i[19:15] == idex_q.rd)
                    || (use_rs2 && instr_i[24:20] == idex_q.rd));
    assign ready   = !stall_i && !load_use;
    assign accept  = instr_valid_i && ready;
    assign ready_o = ready;

    // While stalled the held indices are re-read so late writebacks land
    assign ra1 = stall_i ? idex_q.rs1 : instr_i[19:15];
    assign ra2 = stall_i ? idex_q.rs2 : instr_i[24:20];

    always_comb begin
        rdata1 = (ra1 == 5'd0) ? 32'd0 : rf_q[ra1];
        rdata2 = (ra2 == 5'd0) ? 32'd0 : rf_q[ra2];
`ifdef KAMIKAZE_DECODE_WB_BYPASS_EN
        if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == ra1) rdata1 = wb_data_i;
        if (wb_we_i && wb_rd_i != 5'd0 && wb_rd_i == ra2) rdata2 = wb_data_i;
`endif
    end

    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d.valid = 1'b0;
        end else if (stall_i) begin
            idex_d.rs1_data = rdata1;
            idex_d.rs2_data = rdata2;
        end else if (accept) begin
            idex_d.valid    = 1'b1;
            idex_d.illegal  = dec_ill;
            idex_d.auipc    = (opc == OPC_AUIPC);
            idex_d.funct7b5 = instr_i[30];
            idex_d.funct3   = instr_i[14:12];
            idex_d.op_class = dec_class;
            idex_d.rs1      = instr_i[19:15];
            idex_d.rs2      = instr_i[24:20];
            idex_d.rd       = dec_rd;
            idex_d.pc       = pc_i;
            idex_d.pc_next  = pc_i + (is_compressed_instr_i ? 32'd2 : 32'd4);
            idex_d.imm      = dec_imm;
            idex_d.rs1_data = rdata1;
            idex_d.rs2_data = rdata2;
        end else begin
            idex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_q <= IDEX_RST;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_q[0] <= 32'd0;
            for (int i = 1; i < 32; i++) rf_q[i] <= REG_INIT;
        end else if (wb_we_i && wb_rd_i != 5'd0) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    assign valid_o    = idex_q.valid;
    assign illegal_o  = idex_q.illegal;
    assign auipc_o    = idex_q.auipc;
    assign funct7b5_o = idex_q.funct7b5;
    assign funct3_o   = idex_q.funct3;
    assign op_class_o = idex_q.op_class;
    assign rs1_o      = idex_q.rs1;
    assign rs2_o      = idex_q.rs2;
    assign rd_o       = idex_q.rd;
    assign pc_o       = idex_q.pc;
    assign pc_next_o  = idex_q.pc_next;
    assign imm_o      = idex_q.imm;
    assign rs1_data_o = idex_q.rs1_data;
    assign rs2_data_o = idex_q.rs2_data;

endmodule

// File: tb/tb_kamikaze_decode.sv
// Self-checking bench for kamikaze_decode: decode vector table, hazard/stall/writeback
// sequences and a randomized run against a spec-level reference model.
module tb_kamikaze_decode;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [31:0] instr_i;
    logic        instr_valid_i, is_compressed_instr_i;
    logic [31:0] pc_i;
    logic        ready_o, stall_i, flush_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] pc_o, pc_next_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  op_class_o, funct3_o;
    logic        funct7b5_o, auipc_o, illegal_o;

    always #5 clk_i = ~clk_i;

    kamikaze_decode dut (
        .clk_i(clk_i), .rst_i(rst_n), .instr_i(instr_i),
        .instr_valid_i(instr_valid_i), .is_compressed_instr_i(is_compressed_instr_i),
        .pc_i(pc_i), .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .pc_next_o(pc_next_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .op_class_o(op_class_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
        .auipc_o(auipc_o), .illegal_o(illegal_o)
    );

    int errors = 0;
    int checks = 0;
    logic last_ready;

    typedef struct {
        logic        valid, ill, aui, f7;
        logic [2:0]  f3, cls;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pcn, imm, d1, d2;
    } mstate_t;

    typedef struct {
        int          cls;
        bit          ill, u1, u2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } mdec_t;

    mstate_t     exp_s;
    logic [31:0] mregs [32];
    bit          mready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic mdec_t mdecode(input logic [31:0] ins);
        mdec_t d;
        byte   fmt;
        d.cls = 0; d.ill = 0; d.u1 = 0; d.u2 = 0; d.rd = ins[11:7];
        fmt = "R";
        case (ins[6:0])
            7'h33: begin d.cls = 0; d.u1 = 1; d.u2 = 1; end
            7'h13: begin d.cls = 1; d.u1 = 1; fmt = "I"; end
            7'h03: begin d.cls = 2; d.u1 = 1; fmt = "I"; end
            7'h23: begin d.cls = 3; d.u1 = 1; d.u2 = 1; fmt = "S"; end
            7'h63: begin d.cls = 4; d.u1 = 1; d.u2 = 1; fmt = "B"; end
            7'h6F: begin d.cls = 5; fmt = "J"; end
            7'h67: begin d.cls = 6; d.u1 = 1; fmt = "I"; end
            7'h37, 7'h17: begin d.cls = 7; fmt = "U"; end
            7'h0F: begin d.cls = 1; d.rd = 0; end
            default: begin d.ill = 1; d.rd = 0; end
        endcase
        case (fmt)
            "I": d.imm = 32'($signed(ins[31:20]));
            "S": d.imm = 32'($signed({ins[31:25], ins[11:7]}));
            "B": d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            "J": d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            "U": d.imm = ins & 32'hFFFF_F000;
            default: d.imm = 32'd0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
`ifdef KAMIKAZE_DECODE_WB_BYPASS_EN
        if (wb_we_i && wb_rd_i == idx) return wb_data_i;
`endif
        return mregs[idx];
    endfunction

    task automatic model_reset();
        exp_s = '{valid: 0, ill: 0, aui: 0, f7: 0, f3: 0, cls: 0, rs1: 0, rs2: 0,
                  rd: 0, pc: 32'h0, pcn: 32'h4, imm: 0, d1: 0, d2: 0};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    endtask

    task automatic model_step();
        mdec_t   d;
        mstate_t n;
        bit      hz;
        d  = mdecode(instr_i);
        hz = exp_s.valid && exp_s.cls == 3'd2 && exp_s.rd != 0 && instr_valid_i
             && ((d.u1 && instr_i[19:15] == exp_s.rd) || (d.u2 && instr_i[24:20] == exp_s.rd));
        mready = !stall_i && !hz;
        n = exp_s;
        if (flush_i) n.valid = 0;
        else if (stall_i) begin
            n.d1 = mread(exp_s.rs1);
            n.d2 = mread(exp_s.rs2);
        end else if (instr_valid_i && mready) begin
            n.valid = 1; n.ill = d.ill; n.aui = (instr_i[6:0] == 7'h17);
            n.f7 = instr_i[30]; n.f3 = instr_i[14:12]; n.cls = 3'(d.cls);
            n.rs1 = instr_i[19:15]; n.rs2 = instr_i[24:20]; n.rd = d.rd;
            n.pc = pc_i; n.pcn = pc_i + (is_compressed_instr_i ? 2 : 4);
            n.imm = d.imm; n.d1 = mread(instr_i[19:15]); n.d2 = mread(instr_i[24:20]);
        end else n.valid = 0;
        if (wb_we_i && wb_rd_i != 0) mregs[wb_rd_i] = wb_data_i;
        exp_s = n;
    endtask

    task automatic compare_all();
        chk("valid", valid_o, exp_s.valid);
        chk("illegal", illegal_o, exp_s.ill);
        chk("auipc", auipc_o, exp_s.aui);
        chk("funct7b5", funct7b5_o, exp_s.f7);
        chk("funct3", funct3_o, exp_s.f3);
        chk("class", op_class_o, exp_s.cls);
        chk("rs1", rs1_o, exp_s.rs1);
        chk("rs2", rs2_o, exp_s.rs2);
        chk("rd", rd_o, exp_s.rd);
        chk("pc", pc_o, exp_s.pc);
        chk("pc_next", pc_next_o, exp_s.pcn);
        chk("imm", imm_o, exp_s.imm);
        chk("rs1_data", rs1_data_o, exp_s.d1);
        chk("rs2_data", rs2_data_o, exp_s.d2);
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic cmp, input logic st, input logic fl, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wd);
        instr_valid_i = iv; instr_i = ins; pc_i = pc; is_compressed_instr_i = cmp;
        stall_i = st; flush_i = fl; wb_we_i = we; wb_rd_i = wrd; wb_data_i = wd;
        #1;
        model_step();
        last_ready = ready_o;
        chk("ready", ready_o, mready);
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [31:0] ins, pc;
        logic        cmp;
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [31:0] imm, pcn;
        logic        ill, aui;
    } vec_t;

    vec_t tv [13];

    initial begin
        tv[0]  = '{32'hFFF00093, 32'h100, 0, 3'd1, 5'd1, 32'hFFFFFFFF, 32'h104, 0, 0};
        tv[1]  = '{32'hFFF00093, 32'h100, 1, 3'd1, 5'd1, 32'hFFFFFFFF, 32'h102, 0, 0};
        tv[2]  = '{32'h00000073, 32'h200, 0, 3'd0, 5'd0, 32'h0,        32'h204, 1, 0};
        tv[3]  = '{32'h123452B7, 32'h204, 0, 3'd7, 5'd5, 32'h12345000, 32'h208, 0, 0};
        tv[4]  = '{32'hFE20AE23, 32'h208, 0, 3'd3, 5'd28, 32'hFFFFFFFC, 32'h20C, 0, 0};
        tv[5]  = '{32'hFE000CE3, 32'h20C, 0, 3'd4, 5'd25, 32'hFFFFFFF8, 32'h210, 0, 0};
        tv[6]  = '{32'h001000EF, 32'hFFFFFFFE, 1, 3'd5, 5'd1, 32'h800, 32'h0, 0, 0};
        tv[7]  = '{32'hFFFFF06F, 32'hFFFFFFFC, 0, 3'd5, 5'd0, 32'hFFFFFFFE, 32'h0, 0, 0};
        tv[8]  = '{32'h7FF100E7, 32'h300, 0, 3'd6, 5'd1, 32'h7FF, 32'h304, 0, 0};
        tv[9]  = '{32'hFFFFF517, 32'h304, 1, 3'd7, 5'd10, 32'hFFFFF000, 32'h306, 0, 1};
        tv[10] = '{32'h0FF0000F, 32'h306, 0, 3'd1, 5'd0, 32'h0, 32'h30A, 0, 0};
        tv[11] = '{32'h00128333, 32'h30A, 0, 3'd0, 5'd6, 32'h0, 32'h30E, 0, 0};
        tv[12] = '{32'h00012283, 32'h30E, 0, 3'd2, 5'd5, 32'h0, 32'h312, 0, 0};

        rst_n = 0; instr_i = 0; instr_valid_i = 0; is_compressed_instr_i = 0;
        pc_i = 0; stall_i = 0; flush_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
        last_ready = 0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1;
        #1;
        chk("rst valid", valid_o, 0);
        chk("rst ready", ready_o, 1);
        chk("rst pc", pc_o, 32'h0);
        chk("rst pc_next", pc_next_o, 32'h4);
        compare_all();

        cyc(1, 32'h00318233, 32'h40, 0, 0, 0, 0, 0, 0);
        chk("rst read x3", rs1_data_o, 32'h0);

        for (int i = 0; i < 13; i++) begin
            cyc(1, tv[i].ins, tv[i].pc, tv[i].cmp, 0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d valid", i), valid_o, 1);
            chk($sformatf("tbl%0d class", i), op_class_o, tv[i].cls);
            chk($sformatf("tbl%0d rd", i), rd_o, tv[i].rd);
            chk($sformatf("tbl%0d imm", i), imm_o, tv[i].imm);
            chk($sformatf("tbl%0d pc_next", i), pc_next_o, tv[i].pcn);
            chk($sformatf("tbl%0d illegal", i), illegal_o, tv[i].ill);
            chk($sformatf("tbl%0d auipc", i), auipc_o, tv[i].aui);
        end

        cyc(1, 32'h00012283, 32'h400, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h00128333, 32'h404, 0, 0, 0, 0, 0, 0);
        chk("lu ready low", last_ready, 0);
        chk("lu bubble", valid_o, 0);
        cyc(1, 32'h00128333, 32'h404, 0, 0, 0, 0, 0, 0);
        chk("lu ready back", last_ready, 1);
        chk("lu add valid", valid_o, 1);
        chk("lu add rd", rd_o, 6);

        cyc(1, 32'hFFF00093, 32'h500, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h00128333, 32'h504, 0, 1, 0, 0, 0, 0);
            chk("stall ready", last_ready, 0);
            chk("stall pc", pc_o, 32'h500);
            chk("stall valid", valid_o, 1);
        end
        cyc(1, 32'h00128333, 32'h504, 0, 1, 1, 0, 0, 0);
        chk("flush valid", valid_o, 0);

        cyc(0, 0, 0, 0, 0, 0, 1, 3, 32'h11111111);
        cyc(1, 32'h00318233, 32'h600, 0, 0, 0, 1, 3, 32'hDEADBEEF);
`ifdef KAMIKAZE_DECODE_WB_BYPASS_EN
        chk("wb rs1", rs1_data_o, 32'hDEADBEEF);
        chk("wb rs2", rs2_data_o, 32'hDEADBEEF);
`else
        chk("wb rs1", rs1_data_o, 32'h11111111);
        chk("wb rs2", rs2_data_o, 32'h11111111);
`endif
        cyc(1, 32'h00318233, 32'h604, 0, 0, 0, 0, 0, 0);
        chk("wb after", rs1_data_o, 32'hDEADBEEF);
        cyc(1, 32'h00000233, 32'h608, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
        chk("x0 same", rs1_data_o, 32'h0);
        cyc(1, 32'h00000233, 32'h60C, 0, 0, 0, 0, 0, 0);
        chk("x0 after", rs2_data_o, 32'h0);

        cyc(1, 32'h00000073, 32'h700, 0, 0, 0, 0, 0, 0);
        chk("ecall illegal", illegal_o, 1);
        chk("ecall rd", rd_o, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [6:0]  opcs [11];
            opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
            ins = $urandom;
            ins[6:0] = ($urandom_range(0, 15) < 11) ? opcs[$urandom_range(0, 10)] : 7'($urandom);
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            cyc(($urandom_range(0, 9) < 8), ins, {$urandom} & 32'hFFFF_FFFE,
                1'($urandom), ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1),
                1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
